// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters with registered active-video,
// sync and start-of-line/frame strobes, all aligned to the presented counts.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [31:0] hPixel,
  output logic [31:0] line,
  output logic        video_active,
  output logic        hSync,
  output logic        vSync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          video_q, video_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          lstart_q, lstart_d;
  logic          fstart_q, fstart_d;
  logic [31:0]   h_ext, v_ext;

  // Advance the counts, then decode the next values so flags never lag the counters.
  always_comb begin
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    video_d  = video_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    lstart_d = 1'b0;
    fstart_d = 1'b0;
    h_ext    = 32'(h_cnt_q);
    v_ext    = 32'(v_cnt_q);
    if (pix_en) begin
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
      h_ext    = 32'(h_cnt_d);
      v_ext    = 32'(v_cnt_d);
      video_d  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
      hsync_d  = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
      lstart_d = (h_cnt_d == '0);
      fstart_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  // Reset parks on the last pixel of a frame so the first enabled edge starts at (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q  <= HW'(H_TOTAL - 1);
      v_cnt_q  <= VW'(V_TOTAL - 1);
      video_q  <= 1'b0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      video_q  <= video_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  assign hPixel       = 32'(h_cnt_q);
  assign line         = 32'(v_cnt_q);
  assign video_active = video_q;
  assign hSync        = hsync_q;
  assign vSync        = vsync_q;
  assign line_start   = lstart_q;
  assign frame_start  = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-timing instance and a small active-high-sync
// instance share stimulus; a behavioural raster model predicts every cycle.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
    logic        va;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;

  logic [31:0] d_h, d_l, s_h, s_l;
  logic d_va, d_hs, d_vs, d_ls, d_fs;
  logic s_va, s_hs, s_vs, s_ls, s_fs;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance timing: index 0 = defaults, 1 = small with active-high syncs.
  int unsigned p_ha[2]  = '{640, 8};
  int unsigned p_hfp[2] = '{16, 2};
  int unsigned p_hs[2]  = '{96, 3};
  int unsigned p_hbp[2] = '{48, 2};
  int unsigned p_va[2]  = '{480, 6};
  int unsigned p_vfp[2] = '{10, 1};
  int unsigned p_vs[2]  = '{2, 2};
  int unsigned p_vbp[2] = '{33, 1};
  bit          p_pol[2] = '{1'b0, 1'b1};

  int unsigned m_h[2];
  int unsigned m_l[2];
  obs_t q_d[$];
  obs_t q_s[$];

  int clk_cnt = 0;
  int last_fs_clk = -1;
  int last_period = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_dflt (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hPixel(d_h), .line(d_l), .video_active(d_va),
    .hSync(d_hs), .vSync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_small (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hPixel(s_h), .line(s_l), .video_active(s_va),
    .hSync(s_hs), .vSync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural prediction of the registered outputs after one clk edge.
  task automatic model_step(input int i, input bit rst, input bit en, output obs_t e);
    int unsigned ht, vt, hb, vb;
    bit ls, fs;
    ht = p_ha[i] + p_hfp[i] + p_hs[i] + p_hbp[i];
    vt = p_va[i] + p_vfp[i] + p_vs[i] + p_vbp[i];
    ls = 1'b0;
    fs = 1'b0;
    if (rst) begin
      m_h[i] = ht - 1;
      m_l[i] = vt - 1;
    end else if (en) begin
      if (m_h[i] == ht - 1) begin
        m_h[i] = 0;
        m_l[i] = (m_l[i] == vt - 1) ? 0 : m_l[i] + 1;
      end else begin
        m_h[i] = m_h[i] + 1;
      end
      ls = (m_h[i] == 0);
      fs = (m_h[i] == 0) && (m_l[i] == 0);
    end
    hb = p_ha[i] + p_hfp[i];
    vb = p_va[i] + p_vfp[i];
    e.h  = m_h[i];
    e.l  = m_l[i];
    e.va = (m_h[i] < p_ha[i]) && (m_l[i] < p_va[i]);
    e.hs = ((m_h[i] >= hb) && (m_h[i] < hb + p_hs[i])) ? p_pol[i] : !p_pol[i];
    e.vs = ((m_l[i] >= vb) && (m_l[i] < vb + p_vs[i])) ? p_pol[i] : !p_pol[i];
    e.ls = ls;
    e.fs = fs;
  endtask

  // Drive one clk of stimulus, push predictions, then pop and compare after the edge.
  task automatic step(input bit rst, input bit en);
    obs_t e, g;
    reset  = rst;
    pix_en = en;
    model_step(0, rst, en, e);
    q_d.push_back(e);
    model_step(1, rst, en, e);
    q_s.push_back(e);
    @(posedge clk);
    #1;
    clk_cnt++;
    g = '{d_h, d_l, d_va, d_hs, d_vs, d_ls, d_fs};
    e = q_d.pop_front();
    check_eq("dflt_cycle", 96'(g), 96'(e));
    g = '{s_h, s_l, s_va, s_hs, s_vs, s_ls, s_fs};
    e = q_s.pop_front();
    check_eq("small_cycle", 96'(g), 96'(e));
    if (s_fs) begin
      if (last_fs_clk >= 0) last_period = clk_cnt - last_fs_clk;
      last_fs_clk = clk_cnt;
    end
  endtask

  initial begin
    int cnt;
    int budget;
    reset  = 1'b1;
    pix_en = 1'b0;

    repeat (3) step(1'b1, 1'b1);
    check_eq("rst_h", 96'(d_h), 96'(799));
    check_eq("rst_l", 96'(d_l), 96'(524));
    check_eq("rst_flags", 96'({d_va, d_hs, d_vs, d_ls, d_fs}), 96'(5'b01100));
    check_eq("rst_small_sync", 96'({s_hs, s_vs}), 96'(2'b00));

    step(1'b0, 1'b1);
    check_eq("first_pos", 96'({d_h, d_l}), 96'(64'd0));
    check_eq("first_flags", 96'({d_va, d_hs, d_vs, d_ls, d_fs}), 96'(5'b11111));
    step(1'b0, 1'b1);
    check_eq("second_h", 96'(d_h), 96'(1));
    check_eq("second_pulses", 96'({d_ls, d_fs}), 96'(2'b00));

    // Count active-low hSync cycles over the rest of line 0 (hPixel 2..799).
    cnt = 0;
    repeat (798) begin
      step(1'b0, 1'b1);
      if (!d_hs) cnt++;
    end
    check_eq("hsync_width", 96'(cnt), 96'(96));
    check_eq("line0_end", 96'(d_h), 96'(799));

    repeat (400) step(1'b0, 1'b1);
    check_eq("frame_period", 96'(last_period), 96'(150));

    for (int k = 0; k < 1000; k++) step(1'b0, k % 2 == 0);
    check_eq("frame_period_half", 96'(last_period), 96'(300));

    // Wait for (799,9) on the default instance, bounded.
    budget = 10000;
    while (!(d_h == 799 && d_l == 9) && budget > 0) begin
      step(1'b0, 1'b1);
      budget--;
    end
    check_eq("line9_reached", 96'(budget > 0), 96'(1));
    step(1'b0, 1'b1);
    check_eq("line10_start", 96'({d_h, d_l, d_va, d_ls}), 96'({32'd0, 32'd10, 2'b11}));

    // Active-high vSync on the small instance spans two whole lines per frame.
    cnt = 0;
    repeat (150) begin
      step(1'b0, 1'b1);
      if (s_vs) cnt++;
    end
    check_eq("vsync_width", 96'(cnt), 96'(30));

    step(1'b1, 1'b0);
    check_eq("midrst_pos", 96'({d_h, d_l}), 96'({32'd799, 32'd524}));
    check_eq("midrst_flags", 96'({d_va, d_hs, d_vs, d_ls, d_fs}), 96'(5'b01100));
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_eq("restart_fs", 96'({d_h, d_l, d_fs, s_fs}), 96'({64'd0, 2'b11}));

    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
